// File: rtl/alarme_zonas_pkg.sv
// Shared definitions for the zoned alarm: state codes, state width and the
// delay-counter width helper.
package alarme_zonas_pkg;

  localparam int EST_W = 3;

  typedef enum logic [EST_W-1:0] {
    ALM_DESARMADO = 3'd0,
    ALM_SAIDA     = 3'd1,
    ALM_ARMADO    = 3'd2,
    ALM_ENTRADA   = 3'd3,
    ALM_DISPARO   = 3'd4
  } estado_t;

  // Wide enough to hold the longer of the two delays minus one, plus a spare bit.
  function automatic int calc_w_cnt(input int atraso_saida, input int atraso_entrada);
    int maior;
    maior = (atraso_saida > atraso_entrada) ? atraso_saida : atraso_entrada;
    return $clog2(maior) + 1;
  endfunction

endpackage

// File: rtl/alarme_zonas_if.sv
// Control/sensor inputs and indicator outputs of the zoned alarm, bundled.
// Control is level-sampled every rising clk edge: there is no valid/ready
// handshake, each input is acted on in the cycle it is sampled.
interface alarme_zonas_if #(
  parameter int N_ZONAS = 4,
  parameter int W_CNT   = 4
);
  import alarme_zonas_pkg::*;

  logic               armar;
  logic               desarmar;
  logic [N_ZONAS-1:0] sensores;
  logic [N_ZONAS-1:0] mascara;
  logic [N_ZONAS-1:0] zona_atraso;
  logic               alarme;
  logic               armado;
  logic [EST_W-1:0]   estado;
  logic [N_ZONAS-1:0] zonas_disparo;
  logic [W_CNT-1:0]   contagem;

  modport master (
    output armar, desarmar, sensores, mascara, zona_atraso,
    input  alarme, armado, estado, zonas_disparo, contagem
  );

  modport slave (
    input  armar, desarmar, sensores, mascara, zona_atraso,
    output alarme, armado, estado, zonas_disparo, contagem
  );
endinterface

// File: rtl/alarme_zonas_contador_atraso.sv
// Loadable down-counter shared by the exit and entry delays; saturates at zero.
module contador_atraso #(
  parameter int W_CNT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [W_CNT-1:0] i_valor,
  input  logic             i_carga,
  input  logic             i_dec,
  output logic [W_CNT-1:0] o_valor,
  output logic             o_zero
);

  logic [W_CNT-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_carga) begin
      r_cnt <= i_valor;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_valor = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/alarme_zonas.sv
// Zoned alarm controller: arm/disarm FSM with exit and entry delays, zone
// masking and a sticky record of violated zones. Outputs decode registers only.
module alarme_zonas
  import alarme_zonas_pkg::*;
#(
  parameter int N_ZONAS        = 4,
  parameter int ATRASO_SAIDA   = 8,
  parameter int ATRASO_ENTRADA = 8
) (
  input logic            clk,
  input logic            rst,
  alarme_zonas_if.slave  bus
);

  localparam int W_CNT = calc_w_cnt(ATRASO_SAIDA, ATRASO_ENTRADA);
  localparam logic [W_CNT-1:0] CARGA_SAIDA   = W_CNT'(ATRASO_SAIDA - 1);
  localparam logic [W_CNT-1:0] CARGA_ENTRADA = W_CNT'(ATRASO_ENTRADA - 1);

  estado_t            r_estado;
  estado_t            w_prox;
  logic [N_ZONAS-1:0] r_zonas;
  logic [N_ZONAS-1:0] w_v;
  logic [N_ZONAS-1:0] w_v_inst;
  logic [N_ZONAS-1:0] w_v_atr;
  logic [W_CNT-1:0]   w_cnt_valor;
  logic [W_CNT-1:0]   w_cnt;
  logic               w_cnt_carga;
  logic               w_cnt_dec;
  logic               w_cnt_zero;
  logic               w_limpa_zonas;

  assign w_v      = bus.sensores & bus.mascara;
  assign w_v_inst = w_v & ~bus.zona_atraso;
  assign w_v_atr  = w_v & bus.zona_atraso;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= ALM_DESARMADO;
    end else begin
      r_estado <= w_prox;
    end
  end

  // Loading zero is how the counter is cleared whenever a delay is abandoned.
  always_comb begin
    w_prox        = r_estado;
    w_cnt_valor   = '0;
    w_cnt_carga   = 1'b0;
    w_cnt_dec     = 1'b0;
    w_limpa_zonas = 1'b0;
    if (bus.desarmar) begin
      w_prox      = ALM_DESARMADO;
      w_cnt_carga = 1'b1;
    end else begin
      case (r_estado)
        ALM_DESARMADO: begin
          if (bus.armar) begin
            w_prox        = ALM_SAIDA;
            w_cnt_valor   = CARGA_SAIDA;
            w_cnt_carga   = 1'b1;
            w_limpa_zonas = 1'b1;
          end
        end
        ALM_SAIDA: begin
          if (w_cnt_zero) begin
            w_prox = ALM_ARMADO;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        ALM_ARMADO: begin
          if (w_v_inst != '0) begin
            w_prox = ALM_DISPARO;
          end else if (w_v_atr != '0) begin
            w_prox      = ALM_ENTRADA;
            w_cnt_valor = CARGA_ENTRADA;
            w_cnt_carga = 1'b1;
          end
        end
        ALM_ENTRADA: begin
          if (w_v_inst != '0) begin
            w_prox      = ALM_DISPARO;
            w_cnt_carga = 1'b1;
          end else if (w_cnt_zero) begin
            w_prox = ALM_DISPARO;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        ALM_DISPARO: begin
          w_prox = ALM_DISPARO;
        end
        default: begin
          w_prox      = ALM_DESARMADO;
          w_cnt_carga = 1'b1;
        end
      endcase
    end
  end

  contador_atraso #(
    .W_CNT (W_CNT)
  ) u_contador (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valor (w_cnt_valor),
    .i_carga (w_cnt_carga),
    .i_dec   (w_cnt_dec),
    .o_valor (w_cnt),
    .o_zero  (w_cnt_zero)
  );

  // The record survives a disarm so the user can see what tripped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zonas <= '0;
    end else if (w_limpa_zonas) begin
      r_zonas <= '0;
    end else if ((r_estado == ALM_ARMADO) || (r_estado == ALM_ENTRADA)) begin
      r_zonas <= r_zonas | w_v;
    end
  end

  assign bus.alarme        = (r_estado == ALM_DISPARO);
  assign bus.armado        = (r_estado == ALM_ARMADO) || (r_estado == ALM_ENTRADA) ||
                             (r_estado == ALM_DISPARO);
  assign bus.estado        = r_estado;
  assign bus.zonas_disparo = r_zonas;
  assign bus.contagem      = w_cnt;

endmodule
